// File: rtl/pc_pkg.sv
// Shared control encodings for the fetch-stage program counter.
package pc_pkg;

   localparam logic [1:0] PC_INC_NORMAL = 2'b00;
   localparam logic [1:0] PC_INC_BRANCH = 2'b01;
   localparam logic [1:0] PC_INC_JUMP   = 2'b10;
   localparam logic [1:0] PC_INC_RETURN = 2'b11;

   typedef enum logic {
      RUN = 1'b0,
      EXC = 1'b1
   } pc_state_t;

endpackage

// File: rtl/ras_stack.sv
// Return-address stack as a circular buffer; pushing when full silently drops the oldest entry.
// One-cycle update; push+pop together replaces the top; overflow flag follows the offending push.
module ras_stack #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] push_data,
   output logic [WIDTH-1:0] top,
   output logic             empty,
   output logic             full,
   output logic             overflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_ptr;
   logic [CW-1:0]    r_count;
   logic             r_overflow;

   logic             w_do_pop;
   logic             w_replace;
   logic             w_push_new;
   logic             w_pop_only;
   logic [PW-1:0]    w_ptr_inc;
   logic [PW-1:0]    w_ptr_dec;

   assign w_do_pop   = pop && !empty;
   assign w_replace  = push && w_do_pop;
   assign w_push_new = push && !w_do_pop;
   assign w_pop_only = w_do_pop && !push;
   assign w_ptr_inc  = r_ptr + PW'(1);
   assign w_ptr_dec  = r_ptr - PW'(1);

   assign top      = r_mem[r_ptr];
   assign empty    = (r_count == '0);
   assign full     = (r_count == CW'(DEPTH));
   assign overflow = r_overflow;

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         r_ptr      <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         // A fresh push into a full buffer lands on the oldest slot.
         r_overflow <= w_push_new && full;
         if (w_push_new) begin
            r_ptr <= w_ptr_inc;
            if (!full) r_count <= r_count + CW'(1);
         end else if (w_pop_only) begin
            r_ptr   <= w_ptr_dec;
            r_count <= r_count - CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_replace)       r_mem[r_ptr]     <= push_data;
      else if (w_push_new) r_mem[w_ptr_inc] <= push_data;
   end

endmodule

// File: rtl/pc_ras.sv
// Fetch-stage PC with precise exception entry/return (EPC) and a call/return address stack.
// New PC appears one cycle after inputs are sampled; stall holds PC and RAS unless exc/eret is taken.
module pc_ras
   import pc_pkg::*;
#(
   parameter int               WIDTH      = 32,
   parameter int               RAS_DEPTH  = 4,
   parameter logic [WIDTH-1:0] RESET_PC   = '0,
   parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'('h40)
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             stall,
   input  logic [1:0]       pc_inc,
   input  logic             alu_branch_result,
   input  logic             call,
   input  logic [WIDTH-1:0] abs_addr,
   input  logic [WIDTH-1:0] branch_addr,
   input  logic             exc,
   input  logic             eret,
   output logic [WIDTH-1:0] current_pc,
   output logic [WIDTH-1:0] epc,
   output logic             in_exc,
   output logic             ras_empty,
   output logic             ras_full,
   output logic             ras_overflow
);

   pc_state_t        r_state;
   pc_state_t        w_state_nxt;
   logic [WIDTH-1:0] r_pc;
   logic [WIDTH-1:0] r_epc;
   logic [WIDTH-1:0] w_pc_nxt;
   logic [WIDTH-1:0] w_epc_nxt;
   logic [WIDTH-1:0] w_pc_plus1;
   logic [WIDTH-1:0] w_ras_top;
   logic             w_push;
   logic             w_pop;

   assign w_pc_plus1 = r_pc + WIDTH'(1);

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         r_state <= RUN;
         r_pc    <= RESET_PC;
         r_epc   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_epc   <= w_epc_nxt;
      end
   end

   // Exception entry/return win over stall; an exc already in EXC or an eret in RUN falls through.
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_epc_nxt   = r_epc;
      w_push      = 1'b0;
      w_pop       = 1'b0;
      if (exc && r_state == RUN) begin
         w_epc_nxt   = r_pc;
         w_pc_nxt    = EXC_VECTOR;
         w_state_nxt = EXC;
      end else if (eret && r_state == EXC) begin
         w_pc_nxt    = r_epc;
         w_state_nxt = RUN;
      end else if (!stall) begin
         case (pc_inc)
            PC_INC_NORMAL: w_pc_nxt = w_pc_plus1;
            PC_INC_BRANCH: w_pc_nxt = alu_branch_result ? w_pc_plus1 + branch_addr : w_pc_plus1;
            PC_INC_JUMP: begin
               w_pc_nxt = abs_addr;
               w_push   = call;
            end
            default: begin
               w_pc_nxt = ras_empty ? abs_addr : w_ras_top;
               w_pop    = !ras_empty;
               w_push   = call;
            end
         endcase
      end
   end

   ras_stack #(
      .WIDTH (WIDTH),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .clr_n     (clr_n),
      .push      (w_push),
      .pop       (w_pop),
      .push_data (w_pc_plus1),
      .top       (w_ras_top),
      .empty     (ras_empty),
      .full      (ras_full),
      .overflow  (ras_overflow)
   );

   assign current_pc = r_pc;
   assign epc        = r_epc;
   assign in_exc     = (r_state == EXC);

endmodule

// File: tb/tb_pc_ras.sv
// Bench for pc_ras: directed scenarios plus a randomized run against a queue-based reference model.
module tb_pc_ras;

   localparam int          DEPTH = 4;
   localparam logic [31:0] EXCV  = 32'h40;

   logic        clk = 1'b0;
   logic        clr_n;
   logic        stall;
   logic [1:0]  pc_inc;
   logic        alu_branch_result;
   logic        call;
   logic [31:0] abs_addr;
   logic [31:0] branch_addr;
   logic        exc;
   logic        eret;
   logic [31:0] current_pc;
   logic [31:0] epc;
   logic        in_exc;
   logic        ras_empty;
   logic        ras_full;
   logic        ras_overflow;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [31:0] m_pc;
   logic [31:0] m_epc;
   logic        m_exc;
   logic        m_ovf;
   logic [31:0] m_ras[$];

   always #5 clk = ~clk;

   pc_ras #(
      .WIDTH      (32),
      .RAS_DEPTH  (DEPTH),
      .RESET_PC   (32'h0),
      .EXC_VECTOR (EXCV)
   ) dut (
      .clk               (clk),
      .clr_n             (clr_n),
      .stall             (stall),
      .pc_inc            (pc_inc),
      .alu_branch_result (alu_branch_result),
      .call              (call),
      .abs_addr          (abs_addr),
      .branch_addr       (branch_addr),
      .exc               (exc),
      .eret              (eret),
      .current_pc        (current_pc),
      .epc               (epc),
      .in_exc            (in_exc),
      .ras_empty         (ras_empty),
      .ras_full          (ras_full),
      .ras_overflow      (ras_overflow)
   );

   task automatic model_reset();
      m_pc  = 32'h0;
      m_epc = 32'h0;
      m_exc = 1'b0;
      m_ovf = 1'b0;
      m_ras.delete();
   endtask

   task automatic model_push(input logic [31:0] v);
      m_ras.push_back(v);
      if (m_ras.size() > DEPTH) begin
         void'(m_ras.pop_front());
         m_ovf = 1'b1;
      end
   endtask

   // Advance the model on the current inputs, then let the DUT take one clock edge.
   task automatic cyc();
      logic [31:0] nx;
      m_ovf = 1'b0;
      if (exc && !m_exc) begin
         m_epc = m_pc;
         m_pc  = EXCV;
         m_exc = 1'b1;
      end else if (eret && m_exc) begin
         m_pc  = m_epc;
         m_exc = 1'b0;
      end else if (!stall) begin
         nx = m_pc + 32'd1;
         if (pc_inc == 2'd1 && alu_branch_result) nx = m_pc + 32'd1 + branch_addr;
         if (pc_inc == 2'd2) begin
            nx = abs_addr;
            if (call) model_push(m_pc + 32'd1);
         end
         if (pc_inc == 2'd3) begin
            if (m_ras.size() > 0) nx = m_ras.pop_back();
            else                  nx = abs_addr;
            if (call) model_push(m_pc + 32'd1);
         end
         m_pc = nx;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      stall = 0; pc_inc = 2'd0; alu_branch_result = 0; call = 0;
      abs_addr = 32'h0; branch_addr = 32'h0; exc = 0; eret = 0;
   endtask

   task automatic goto_pc(input logic [31:0] a);
      idle();
      pc_inc   = 2'd2;
      abs_addr = a;
      cyc();
      idle();
   endtask

   task automatic pulse_reset();
      clr_n = 1'b0;
      #1;
      model_reset();
      clr_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      idle();
      clr_n = 1'b0;
      model_reset();
      #7;
      checks++; if (current_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want %h", current_pc, 32'h0); end
      checks++; if (epc !== 32'h0) begin errors++; $display("FAIL reset_epc: got %h want %h", epc, 32'h0); end
      checks++; if (in_exc !== 1'b0) begin errors++; $display("FAIL reset_in_exc: got %b want 0", in_exc); end
      checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", ras_empty); end
      checks++; if (ras_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", ras_full); end
      checks++; if (ras_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ras_overflow); end
      #1;
      clr_n = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         cyc();
         checks++; if (current_pc !== 32'(i)) begin errors++; $display("FAIL reset_inc%0d: got %h want %h", i, current_pc, 32'(i)); end
      end
      #2;
      clr_n = 1'b0;
      #1;
      checks++; if (current_pc !== 32'h0) begin errors++; $display("FAIL async_reset_pc: got %h want %h", current_pc, 32'h0); end
      model_reset();
      #1;
      clr_n = 1'b1;
   endtask

   task automatic test_branch_jump();
      goto_pc(32'd10);
      pc_inc = 2'd1; alu_branch_result = 1; branch_addr = 32'hFFFF_FFFC;
      cyc();
      checks++; if (current_pc !== 32'd7) begin errors++; $display("FAIL branch_taken: got %h want %h", current_pc, 32'd7); end
      goto_pc(32'd10);
      pc_inc = 2'd1; alu_branch_result = 0; branch_addr = 32'hFFFF_FFFC;
      cyc();
      checks++; if (current_pc !== 32'd11) begin errors++; $display("FAIL branch_not_taken: got %h want %h", current_pc, 32'd11); end
      goto_pc(32'd10);
      pc_inc = 2'd2; abs_addr = 32'h100;
      cyc();
      checks++; if (current_pc !== 32'h100) begin errors++; $display("FAIL jump: got %h want %h", current_pc, 32'h100); end
      goto_pc(32'hFFFF_FFFF);
      cyc();
      checks++; if (current_pc !== 32'h0) begin errors++; $display("FAIL wrap: got %h want %h", current_pc, 32'h0); end
   endtask

   task automatic test_call_return();
      goto_pc(32'd5);
      pc_inc = 2'd2; call = 1; abs_addr = 32'h20;
      cyc();
      checks++; if (current_pc !== 32'h20) begin errors++; $display("FAIL call_target: got %h want %h", current_pc, 32'h20); end
      checks++; if (ras_empty !== 1'b0) begin errors++; $display("FAIL call_nonempty: got %b want 0", ras_empty); end
      goto_pc(32'h25);
      pc_inc = 2'd3; abs_addr = 32'h99;
      cyc();
      checks++; if (current_pc !== 32'd6) begin errors++; $display("FAIL return_addr: got %h want %h", current_pc, 32'd6); end
      checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL return_empty: got %b want 1", ras_empty); end
      pc_inc = 2'd3; abs_addr = 32'h77;
      cyc();
      checks++; if (current_pc !== 32'h77) begin errors++; $display("FAIL return_fallback: got %h want %h", current_pc, 32'h77); end
      idle();
   endtask

   task automatic test_overflow();
      logic [31:0] want;
      goto_pc(32'h200);
      for (int i = 0; i < 5; i++) begin
         pc_inc = 2'd2; call = 1; abs_addr = 32'h300 + 32'(i * 16);
         cyc();
         checks++; if (ras_overflow !== (i == 4)) begin errors++; $display("FAIL ovf_call%0d: got %b want %b", i, ras_overflow, (i == 4)); end
         checks++; if (ras_full !== (i >= 3)) begin errors++; $display("FAIL full_call%0d: got %b want %b", i, ras_full, (i >= 3)); end
      end
      for (int j = 0; j < 4; j++) begin
         pc_inc = 2'd3; call = 0; abs_addr = 32'h999;
         cyc();
         want = 32'h331 - 32'(j * 16);
         checks++; if (current_pc !== want) begin errors++; $display("FAIL lifo%0d: got %h want %h", j, current_pc, want); end
         checks++; if (ras_overflow !== 1'b0) begin errors++; $display("FAIL ovf_pop%0d: got %b want 0", j, ras_overflow); end
      end
      checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL ovf_drained: got %b want 1", ras_empty); end
      cyc();
      checks++; if (current_pc !== 32'h999) begin errors++; $display("FAIL oldest_lost: got %h want %h", current_pc, 32'h999); end
      idle();
   endtask

   task automatic test_exception();
      goto_pc(32'h30);
      exc = 1; stall = 1;
      cyc();
      checks++; if (current_pc !== 32'h40) begin errors++; $display("FAIL exc_pc: got %h want %h", current_pc, 32'h40); end
      checks++; if (epc !== 32'h30) begin errors++; $display("FAIL exc_epc: got %h want %h", epc, 32'h30); end
      checks++; if (in_exc !== 1'b1) begin errors++; $display("FAIL exc_flag: got %b want 1", in_exc); end
      idle(); exc = 1;
      cyc();
      checks++; if (current_pc !== 32'h41) begin errors++; $display("FAIL nested_exc_pc: got %h want %h", current_pc, 32'h41); end
      checks++; if (epc !== 32'h30) begin errors++; $display("FAIL nested_exc_epc: got %h want %h", epc, 32'h30); end
      idle(); eret = 1;
      cyc();
      checks++; if (current_pc !== 32'h30) begin errors++; $display("FAIL eret_pc: got %h want %h", current_pc, 32'h30); end
      checks++; if (in_exc !== 1'b0) begin errors++; $display("FAIL eret_flag: got %b want 0", in_exc); end
      cyc();
      checks++; if (current_pc !== 32'h31) begin errors++; $display("FAIL eret_run: got %h want %h", current_pc, 32'h31); end
      idle();
   endtask

   task automatic test_stall();
      goto_pc(32'h50);
      pc_inc = 2'd2; call = 1; abs_addr = 32'h60; stall = 1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         checks++; if (current_pc !== 32'h50) begin errors++; $display("FAIL stall_pc%0d: got %h want %h", i, current_pc, 32'h50); end
         checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL stall_ras%0d: got %b want 1", i, ras_empty); end
      end
      stall = 0;
      cyc();
      checks++; if (current_pc !== 32'h60) begin errors++; $display("FAIL stall_release: got %h want %h", current_pc, 32'h60); end
      idle(); pc_inc = 2'd3; abs_addr = 32'h77;
      cyc();
      checks++; if (current_pc !== 32'h51) begin errors++; $display("FAIL stall_ret: got %h want %h", current_pc, 32'h51); end
      cyc();
      checks++; if (current_pc !== 32'h77) begin errors++; $display("FAIL stall_single_push: got %h want %h", current_pc, 32'h77); end
      idle();
   endtask

   task automatic test_random();
      int off;
      pulse_reset();
      for (int n = 0; n < 400; n++) begin
         stall             = ($urandom_range(0, 3) == 0);
         pc_inc            = 2'($urandom_range(0, 3));
         alu_branch_result = 1'($urandom_range(0, 1));
         call              = 1'($urandom_range(0, 1));
         abs_addr          = $urandom;
         off               = int'($urandom_range(0, 15)) - 8;
         branch_addr       = 32'(off);
         exc               = ($urandom_range(0, 15) == 0);
         eret              = ($urandom_range(0, 7) == 0);
         cyc();
         checks++; if (current_pc !== m_pc) begin errors++; $display("FAIL rnd_pc@%0d: got %h want %h", n, current_pc, m_pc); end
         checks++; if (epc !== m_epc) begin errors++; $display("FAIL rnd_epc@%0d: got %h want %h", n, epc, m_epc); end
         checks++; if (in_exc !== m_exc) begin errors++; $display("FAIL rnd_in_exc@%0d: got %b want %b", n, in_exc, m_exc); end
         checks++; if (ras_empty !== (m_ras.size() == 0)) begin errors++; $display("FAIL rnd_empty@%0d: got %b want %b", n, ras_empty, (m_ras.size() == 0)); end
         checks++; if (ras_full !== (m_ras.size() == DEPTH)) begin errors++; $display("FAIL rnd_full@%0d: got %b want %b", n, ras_full, (m_ras.size() == DEPTH)); end
         checks++; if (ras_overflow !== m_ovf) begin errors++; $display("FAIL rnd_ovf@%0d: got %b want %b", n, ras_overflow, m_ovf); end
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_branch_jump();
      test_call_return();
      test_overflow();
      test_exception();
      test_stall();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_ras.md
Name: pc_ras

Overview:
- Next-generation program-counter unit. Holds the PC internally rather than taking a last_pc input.
- Adds the following over the basic PC unit:
  - parametrised width and reset address
  - stall hold
  - precise exception entry/return with EPC
  - return-address stack (RAS) for call/return
- Sits at the head of the fetch stage. Feeds current_pc to instruction memory. Takes control from the decoder and ALU.
- All addresses are word addresses (low bits ignored). Normal increment is +1.

Parameters:
- WIDTH, 32, PC/address width in bits.
- RAS_DEPTH, 4, number of RAS entries (>=2, power of two).
- RESET_PC, 0, PC value loaded on reset.
- EXC_VECTOR, 'h40, PC loaded on exception entry.

Ports:
- clk  in  1  clock; all state updates on posedge.
- clr_n  in  1  asynchronous active-low reset.
- stall  in  1  hold PC and RAS this cycle.
- pc_inc  in  2  00 normal, 01 branch, 10 jump, 11 return.
- alu_branch_result  in  1  branch taken when pc_inc=01.
- call  in  1  with pc_inc=10 or 11: push return address (current_pc+1).
- abs_addr  in  WIDTH  jump target; also the return fallback target.
- branch_addr  in  WIDTH  signed branch offset.
- exc  in  1  exception request.
- eret  in  1  return from exception.
- current_pc  out  WIDTH  PC of the instruction being fetched.
- epc  out  WIDTH  saved exception PC.
- in_exc  out  1  exception state flag.
- ras_empty  out  1  RAS holds zero entries.
- ras_full  out  1  RAS holds RAS_DEPTH entries.
- ras_overflow  out  1  one-cycle pulse when a push overwrote the oldest entry.

Behaviour:
- Reset (clr_n low, async): current_pc=RESET_PC, epc=0, state=RUN, RAS count=0, ras_empty=1, ras_full=0, ras_overflow=0.
- States: RUN, EXC. in_exc = (state==EXC).
- Per posedge, priority is highest first:
  1. exc while RUN:
     - epc<=current_pc, current_pc<=EXC_VECTOR, state<=EXC.
     - Overrides stall. RAS unchanged.
  2. exc while EXC: ignored (no nesting). Evaluation continues to the next rule.
  3. eret while EXC:
     - current_pc<=epc, state<=RUN.
     - Overrides stall. RAS unchanged.
  4. eret while RUN: ignored. Evaluation continues to the next rule.
  5. stall: everything holds; ras_overflow=0.
  6. pc_inc decode:
     - 00: current_pc+1.
     - 01: alu_branch_result ? current_pc+1+branch_addr : current_pc+1.
     - 10: abs_addr.
     - 11: RAS top if !ras_empty (then pop), else abs_addr (no pop).
- Arithmetic: all sums are modulo 2^WIDTH. branch_addr is treated as two's complement. Wrap is silent (e.g. all-ones +1 gives 0).
- Latency: the new PC is visible on current_pc one cycle after the controlling inputs are sampled.
- call with pc_inc=10: push current_pc+1.
- call with pc_inc=11 (tail call): pop then push in the same cycle. The net effect replaces the top with current_pc+1; count is unchanged, or +1 if the stack was empty.
- call with pc_inc=00/01: ignored.
- Push when full:
  - The circular buffer overwrites the oldest entry and count stays RAS_DEPTH.
  - ras_overflow pulses high for that cycle only.
- Pop when empty: never happens (fallback rule above). Count never underflows.
- The RAS holds contents across exception entry and return.
- Reset asserted mid-operation clears everything immediately, independent of clk.

Decomposition:
- Package pc_pkg holds:
  - the PC_INC_NORMAL/BRANCH/JUMP/RETURN 2-bit constants
  - the pc_state_t enum {RUN, EXC}
- One sub-module, ras_stack (params WIDTH, DEPTH):
  - inputs: push, pop, push_data
  - outputs: top, empty, full, overflow
  - implemented as a circular buffer with top pointer and count.
- The top level holds the FSM, next-PC mux, and EPC register.

Test Plan:
- Reset then 3 normal cycles, RESET_PC=0 → current_pc 0,1,2,3. Asserting clr_n low mid-cycle → current_pc=0 immediately.
- At pc=10:
  - branch taken, branch_addr=-4 → 7
  - branch not taken → 11
  - jump abs_addr=0x100 → 0x100
  - pc='hFFFFFFFF with normal increment → 0.
- At pc=5, call+jump to 0x20, then return at pc=0x25 → 0x20 then 6, ras_empty=1. Return when empty with abs_addr=0x77 → 0x77.
- RAS_DEPTH=4: five nested calls → ras_overflow pulses on the 5th only. Four returns yield the last four return addresses (LIFO). The oldest is lost, then ras_empty=1.
- At pc=0x30, exc together with stall → pc=0x40, epc=0x30, in_exc=1. A second exc is ignored. eret → pc=0x30, in_exc=0. eret in RUN behaves as normal increment.
- stall for 3 cycles during call+jump → PC and RAS unchanged. Release → the push happens exactly once.
